// File: rtl/data_memory.sv
// Data-side load/store responder for the rv32i core: valid/ready request in,
// configurable wait states, byte-lane stores, extended loads, fault flagging.
module data_memory #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_width,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state, next_state;
   logic [3:0]        wait_cnt;
   logic              lat_write, lat_unsigned;
   logic [31:0]       lat_addr, lat_wdata;
   logic [1:0]        lat_width;
   logic [31:0]       mem [DEPTH_WORDS];

   logic              accept, enter_resp;
   logic              cur_write, cur_unsigned;
   logic [31:0]       cur_addr, cur_wdata, offset;
   logic [1:0]        cur_width, lane;
   logic [IDX_W-1:0]  word_idx;
   logic              acc_err;
   logic [3:0]        byte_en;
   logic [31:0]       wdata_lanes, rd_word, rd_shift, load_data;

   assign accept     = req_valid && req_ready;
   assign enter_resp = (next_state == RESP) && (state != RESP);

   // With zero wait states the commit happens on the accept edge itself, so
   // the datapath looks at the live request in IDLE and the latched copy after.
   always_comb begin
      if (state == IDLE) begin
         cur_write    = req_write;
         cur_addr     = req_addr;
         cur_wdata    = req_wdata;
         cur_width    = req_width;
         cur_unsigned = req_unsigned;
      end else begin
         cur_write    = lat_write;
         cur_addr     = lat_addr;
         cur_wdata    = lat_wdata;
         cur_width    = lat_width;
         cur_unsigned = lat_unsigned;
      end
   end

   assign offset   = cur_addr - BASE_ADDR;
   assign word_idx = offset[IDX_W+1:2];
   assign lane     = cur_addr[1:0];

   always_comb begin
      acc_err = ({1'b0, offset} >= MEM_BYTES);
      case (cur_width)
         2'b01:   acc_err = acc_err || lane[0];
         2'b10:   acc_err = acc_err || (lane != 2'b00);
         2'b11:   acc_err = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      byte_en     = 4'b0000;
      wdata_lanes = cur_wdata;
      case (cur_width)
         2'b00: begin
            byte_en     = 4'b0001 << lane;
            wdata_lanes = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            byte_en     = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{cur_wdata[15:0]}};
         end
         2'b10:   byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   end

   assign rd_word  = mem[word_idx];
   assign rd_shift = rd_word >> {lane, 3'b000};

   always_comb begin
      case (cur_width)
         2'b00:   load_data = cur_unsigned ? {24'h0, rd_shift[7:0]}
                                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   load_data = cur_unsigned ? {16'h0, rd_shift[15:0]}
                                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: load_data = rd_word;
      endcase
   end

   // NOTE: storage has no reset branch so it maps onto plain RAM; its
   // contents are undefined until written.
   always_ff @(posedge clk) begin
      if (enter_resp && cur_write && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT:    if (wait_cnt == 4'd0) next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // req_ready is gated by rst so it reads 0 for the whole reset pulse.
   always_comb begin
      req_ready = (state == IDLE) && !rst;
      rsp_valid = (state == RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt     <= 4'd0;
         lat_write    <= 1'b0;
         lat_addr     <= 32'h0;
         lat_wdata    <= 32'h0;
         lat_width    <= 2'b00;
         lat_unsigned <= 1'b0;
         rsp_rdata    <= 32'h0;
         rsp_err      <= 1'b0;
      end else begin
         if (accept) begin
            wait_cnt     <= WAIT_LOAD;
            lat_write    <= req_write;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            lat_width    <= req_width;
            lat_unsigned <= req_unsigned;
         end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         if (enter_resp) begin
            rsp_rdata <= (!cur_write && !acc_err) ? load_data : 32'h0;
            rsp_err   <= acc_err;
         end else if (state == RESP && rsp_ready) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
         end
      end
   end

endmodule

// File: doc/data_memory.md
# data_memory

Data-side memory responder for the rv32i core: services the load/store requests that the decoder's `mem_read`/`mem_write`/`mem_width` controls produce, the counterpart to the instruction-fetch path.

- Requests are accepted over a valid/ready handshake.
- Each access is held for a configurable number of wait states.
- Stores are committed with byte-lane masking.
- Loads return aligned, sign- or zero-extended data over a second valid/ready handshake.
- Misaligned, illegal-width and out-of-range accesses are flagged.

## Interface
- `DEPTH_WORDS`, default 1024: storage size in 32-bit words; power of two.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; multiple of 4.
- `WAIT_CYCLES`, default 2: wait states between accept and response; 0..15.
- `clk`  in  1  sole clock; all state on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_width`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  access faulted.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid` the block latches write, addr, wdata, width and unsigned.
  - Next state is WAIT, or RESP directly if `WAIT_CYCLES` = 0.
- WAIT:
  - `req_ready` = 0.
  - A 4-bit counter loads `WAIT_CYCLES`-1 at accept and decrements each cycle.
  - At 0 the FSM moves to RESP.
- Error check, evaluated on the latched request; any one of these sets `rsp_err`:
  - width 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - (addr − BASE_ADDR) ≥ DEPTH_WORDS*4, using a 32-bit unsigned subtract that may wrap.
- Commit happens on the edge entering RESP:
  - Store, no error: write only the addressed lanes. Byte writes lane addr[1:0]; half writes lanes {addr[1],0} and {addr[1],1}; word writes all 4 lanes.
  - Load, no error: read the word and shift the lane down to bit 0. Extend bit 7 (byte) or bit 15 (half) unless `req_unsigned`. Register the result in `rsp_rdata`.
  - Error: no write; `rsp_rdata` = 0.
- RESP:
  - `rsp_valid` = 1, and `rsp_rdata`/`rsp_err` are held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready` the FSM returns to IDLE and clears `rsp_valid`, `rsp_rdata` and `rsp_err`.
- Word index = (addr − BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
- Storage contents are not reset and are undefined at power-up.

## Timing
- Reset values: `req_ready` = 1 once `rst` deasserts (0 while asserted). `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- The request is accepted at rising edge k, when `req_valid && req_ready` is sampled.
- `rsp_valid` is high from edge k + WAIT_CYCLES + 1 when `WAIT_CYCLES` > 0, and from edge k + 1 when `WAIT_CYCLES` = 0.
- Minimum spacing between accepts is WAIT_CYCLES + 2 cycles when `rsp_ready` is held high. There is no accept in the same cycle as the response handshake.
- `req_*` inputs are ignored outside the accept cycle and may change freely afterwards.
- `rsp_ready` low stalls indefinitely in RESP with no change on any output.
- Read-after-write: a load accepted after a store's response returns the stored data.
- Reset mid-operation forces IDLE immediately:
  - reset during WAIT drops a pending store (memory unchanged);
  - reset during RESP discards the response; the already-committed store remains.

## Test plan
- Word store 32'hDEADBEEF to 0x10, then word load 0x10 with `WAIT_CYCLES`=2 → `rsp_rdata`=32'hDEADBEEF, `rsp_err`=0, `rsp_valid` at edge k+3.
- After the above, signed byte load 0x13 → 32'hFFFFFFDE; unsigned byte load 0x13 → 32'h000000DE; signed half load 0x10 → 32'hFFFFBEEF.
- Byte store 8'h55 to 0x11 over 32'hDEADBEEF, then word load 0x10 → 32'hDEAD55EF.
- Half load 0x11, word store 0x12, width 11, and word load at BASE_ADDR+DEPTH_WORDS*4 → `rsp_err`=1, `rsp_rdata`=0; a subsequent word load 0x10 shows memory unchanged.
- Hold `rsp_ready`=0 for 5 cycles during a response → `rsp_valid`/`rsp_rdata` stable and `req_ready`=0 throughout; handshake, then `req_ready`=1 the next cycle.
- Assert `rst` during WAIT of a store 32'h12345678 to 0x20 → outputs go to reset values asynchronously; a later load of 0x20 returns the prior contents. Repeat with `WAIT_CYCLES`=0 and confirm 1-cycle latency.
